// File: rtl/opcode_fetch.sv
// opcode_fetch: byte-wide instruction fetch and prefetch FIFO feeding the microcode sequencer.
// Ports:
//   clk, rst_b                  clock, asynchronous active-low reset
//   mc__more_2a, mc__stall      hold the head entry (no pop)
//   redirect_4a, redirect_pc_4a flush FIFO and restart fetch at redirect_pc_4a
//   imem_req, imem_addr         single-outstanding memory request, address held until ack
//   imem_ack, imem_data         request completion and fetched byte
//   opcode, opcode_valid        head byte (NOP_OPCODE when empty) and its valid flag
//   opcode_pc                   address of the head byte, zero when empty
module opcode_fetch #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [7:0]  NOP_OPCODE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mc__more_2a,
    input  logic        mc__stall,
    input  logic        redirect_4a,
    input  logic [31:0] redirect_pc_4a,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_data,
    output logic [7:0]  opcode,
    output logic        opcode_valid,
    output logic [31:0] opcode_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic [7:0]    byte_mem_q [DEPTH];
    logic [7:0]    byte_mem_d [DEPTH];
    logic          push, pop;

    // Only a live (non-discarded) request that completes without a kill is kept.
    assign push         = (state_q == REQ) && imem_ack && !redirect_4a;
    assign opcode_valid = count_q != '0;
    assign pop          = opcode_valid && !mc__more_2a && !mc__stall && !redirect_4a;
    assign opcode       = opcode_valid ? byte_mem_q[rd_ptr_q] : NOP_OPCODE;
    assign opcode_pc    = opcode_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign imem_req     = state_q != IDLE;
    assign imem_addr    = addr_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        pc_mem_d   = pc_mem_q;
        byte_mem_d = byte_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]   = addr_q;
            byte_mem_d[wr_ptr_q] = imem_data;
            fetch_pc_d           = fetch_pc_q + 32'd1;
        end
        // A request is only issued from IDLE, where nothing is in flight, so
        // count < DEPTH already reserves the slot its ack will fill.
        case (state_q)
            IDLE: begin
                if (!redirect_4a && count_q < FULL) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ:     state_d = imem_ack ? IDLE : (redirect_4a ? DISCARD : REQ);
            DISCARD: state_d = imem_ack ? IDLE : DISCARD;
            default: state_d = IDLE;
        endcase
        if (redirect_4a) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc_4a;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                byte_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_mem_q   <= pc_mem_d;
            byte_mem_q <= byte_mem_d;
        end
    end
endmodule

// File: tb/tb_opcode_fetch.sv
// tb_opcode_fetch: vector table plus scoreboard bench for opcode_fetch.
module tb_opcode_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [7:0]  NOP      = 8'hEE;

    logic        clk = 1'b0, rst_b = 1'b0;
    logic        mc__more_2a = 1'b0, mc__stall = 1'b0, redirect_4a = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc_4a = '0;
    logic [7:0]  imem_data = '0;
    logic        imem_req, opcode_valid;
    logic [31:0] imem_addr, opcode_pc;
    logic [7:0]  opcode;

    opcode_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_OPCODE(NOP)) dut (
        .clk(clk), .rst_b(rst_b), .mc__more_2a(mc__more_2a), .mc__stall(mc__stall),
        .redirect_4a(redirect_4a), .redirect_pc_4a(redirect_pc_4a),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .opcode(opcode), .opcode_valid(opcode_valid), .opcode_pc(opcode_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic more; logic req; logic [31:0] addr; logic valid; logic [7:0] op; logic [31:0] pc; } vec_t;
    typedef struct { logic [31:0] pc; logic [7:0] b; } ent_t;

    vec_t        tbl [14];
    ent_t        q [$];
    int          tests = 0, fails = 0, wcnt = 0, lat = 0;
    logic        more_v = 0, stall_v = 0, redir_v = 0, force_ack = 0, disc = 0, found;
    logic [31:0] rpc_v = '0, fpc = RESET_PC, old_addr;

    task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives this cycle's inputs, plays the memory, and runs the scoreboard.
    task automatic eval();
        logic mem_ok, kept;
        mc__more_2a    = more_v;
        mc__stall      = stall_v;
        redirect_4a    = redir_v;
        redirect_pc_4a = rpc_v;
        mem_ok = 1'b0;
        if (force_ack) begin
            imem_ack  = 1'b1;
            imem_data = 8'h5A;
        end else if (rst_b && imem_req) begin
            if (wcnt >= lat) begin
                imem_ack  = 1'b1;
                imem_data = imem_addr[7:0];
                wcnt      = 0;
                mem_ok    = 1'b1;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
        if (!rst_b) begin
            q.delete();
            fpc  = RESET_PC;
            disc = 1'b0;
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, RESET_PC);
            chk("rst_valid", opcode_valid, 0);
            chk("rst_opcode", opcode, NOP);
            chk("rst_pc", opcode_pc, 0);
            return;
        end
        chk("sb_valid", opcode_valid, q.size() != 0);
        if (q.size() == 0) begin
            chk("sb_nop", opcode, NOP);
            chk("sb_pc0", opcode_pc, 0);
        end else begin
            chk("sb_opcode", opcode, q[0].b);
            chk("sb_pc", opcode_pc, q[0].pc);
            if (!more_v && !stall_v && !redir_v) void'(q.pop_front());
        end
        kept = mem_ok && !disc && !redir_v;
        if (mem_ok) disc = 1'b0;
        if (redir_v) begin
            q.delete();
            fpc = rpc_v;
            if (imem_req && !imem_ack) disc = 1'b1;
        end
        if (kept) begin
            q.push_back('{fpc, fpc[7:0]});
            fpc++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        eval();
    endtask

    task automatic run_table(input logic late_ack);
        for (int i = 0; i < 14; i++) begin
            more_v    = tbl[i].more;
            force_ack = late_ack && (i == 0);
            cycle();
            chk("tbl_req", imem_req, tbl[i].req);
            chk("tbl_addr", imem_addr, tbl[i].addr);
            chk("tbl_valid", opcode_valid, tbl[i].valid);
            chk("tbl_opcode", opcode, tbl[i].op);
            chk("tbl_pc", opcode_pc, tbl[i].pc);
        end
        force_ack = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 32'h0, 0, NOP,   32'h0};
        tbl[1]  = '{0, 1, 32'h0, 0, NOP,   32'h0};
        tbl[2]  = '{0, 0, 32'h0, 1, 8'h00, 32'h0};
        tbl[3]  = '{0, 1, 32'h1, 0, NOP,   32'h0};
        tbl[4]  = '{0, 0, 32'h1, 1, 8'h01, 32'h1};
        tbl[5]  = '{0, 1, 32'h2, 0, NOP,   32'h0};
        tbl[6]  = '{1, 0, 32'h2, 1, 8'h02, 32'h2};
        tbl[7]  = '{1, 1, 32'h3, 1, 8'h02, 32'h2};
        tbl[8]  = '{1, 0, 32'h3, 1, 8'h02, 32'h2};
        tbl[9]  = '{1, 1, 32'h4, 1, 8'h02, 32'h2};
        tbl[10] = '{1, 0, 32'h4, 1, 8'h02, 32'h2};
        tbl[11] = '{1, 1, 32'h5, 1, 8'h02, 32'h2};
        tbl[12] = '{1, 0, 32'h5, 1, 8'h02, 32'h2};
        tbl[13] = '{1, 0, 32'h5, 1, 8'h02, 32'h2};

        repeat (3) cycle();
        @(posedge clk);
        #1 rst_b = 1'b1;
        run_table(1'b0);
        repeat (2) cycle();
        more_v = 1'b0;
        repeat (30) cycle();

        lat   = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (imem_req && !imem_ack) found = 1'b1;
        end
        chk("req_outstanding_seen", found, 1);
        old_addr = imem_addr;
        redir_v  = 1'b1;
        rpc_v    = 32'h100;
        cycle();
        redir_v = 1'b0;
        cycle();
        chk("discard_req", imem_req, 1);
        chk("discard_addr", imem_addr, old_addr);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (opcode_valid) found = 1'b1;
        end
        chk("redir_valid_seen", found, 1);
        chk("redir_first_pc", opcode_pc, 32'h100);
        chk("redir_first_op", opcode, 8'h00);

        lat    = 0;
        more_v = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (imem_req && opcode_valid) begin
                more_v  = 1'b0;
                redir_v = 1'b1;
                rpc_v   = 32'h200;
                found   = 1'b1;
            end
            eval();
        end
        redir_v = 1'b0;
        more_v  = 1'b0;
        chk("redir_ack_seen", found, 1);
        cycle();
        chk("flush_valid", opcode_valid, 0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (imem_req) found = 1'b1;
        end
        chk("redir_req_seen", found, 1);
        chk("redir_req_addr", imem_addr, 32'h200);
        repeat (6) cycle();

        stall_v = 1'b1;
        repeat (14) cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_full_noreq", imem_req, 0);
            chk("stall_full_valid", opcode_valid, 1);
        end
        stall_v = 1'b0;
        repeat (20) cycle();

        lat   = 5;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (imem_req) found = 1'b1;
        end
        chk("pre_reset_req", found, 1);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        force_ack = 1'b1;
        eval();
        repeat (2) cycle();
        @(posedge clk);
        #1 rst_b = 1'b1;
        lat = 0;
        run_table(1'b1);
        more_v = 1'b0;
        repeat (12) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
